viol_reset_ctrl: RTL and testbench
==================================

VIOL_RESET_CTRL -- requirements
Module: viol_reset_ctrl

Interface
REQ-001 The parameter list SHALL be: HOLD_CYCLES, 8'd8, number of cycles cpu_rst is held per violation (0 behaves as 1).
REQ-002 The parameter list SHALL include: RESET_HANDLER, 16'h0000, PC value that marks completion of reset recovery.
REQ-003 The port list SHALL begin: clk  input  1  sole clock, all state on rising edge.
REQ-004 The port list SHALL continue: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 The port list SHALL continue: pc  input  16  current CPU program counter.
REQ-006 The port list SHALL continue: vrased_viol, casu_viol, garota_viol  input  1 each  per-monitor violation request, level, sampled each edge.
REQ-007 The port list SHALL continue: cause_clr  input  1  software clear of the sticky cause register.
REQ-008 The port list SHALL continue: cpu_rst  output  1  registered reset to the CPU core, active-high.
REQ-009 The port list SHALL continue: rst_cause  output  3  sticky cause bits {garota,casu,vrased}.
REQ-010 The port list SHALL continue: rst_count  output  8  saturating count of violation-triggered resets.
REQ-011 The port list SHALL end: busy  output  1  high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, HOLD and WAIT_PC; cpu_rst SHALL be 1 exactly when the state is HOLD.
REQ-013 In IDLE, any violation input high at an edge SHALL move the FSM to HOLD, load the hold timer with max(HOLD_CYCLES,1)-1, OR the active violation bits into rst_cause, and increment rst_count.
REQ-014 cpu_rst SHALL rise on the same edge that samples the violation, with one-edge latency, and SHALL stay high for exactly max(HOLD_CYCLES,1) cycles when no further violation arrives.
REQ-015 In HOLD, the timer SHALL decrement each cycle; at timer==0 with no violation present, the FSM SHALL go to WAIT_PC.
REQ-016 A violation during HOLD SHALL OR its bits into rst_cause and reload the timer, extending the hold, and SHALL NOT increment rst_count.
REQ-017 In WAIT_PC, pc==RESET_HANDLER SHALL return the FSM to IDLE.
REQ-018 In WAIT_PC, a violation SHALL re-enter HOLD with the same actions as REQ-013; a violation SHALL take priority over a pc match on the same edge.
REQ-019 rst_count SHALL saturate at 8'hFF and SHALL be cleared only by reset_n.
REQ-020 cause_clr SHALL clear rst_cause only in IDLE with no violation present; if a violation is present on the same edge, rst_cause SHALL take the new violation bits only; cause_clr SHALL be ignored in HOLD and WAIT_PC.
REQ-021 Simultaneous violations from several monitors SHALL set all corresponding cause bits and count as one reset.

Reset
REQ-022 While reset_n is low, the block SHALL be in state HOLD, cpu_rst=1, busy=1, rst_cause=0, rst_count=0, and the timer loaded with max(HOLD_CYCLES,1)-1.
REQ-023 After reset_n rises, the block SHALL complete the hold, then follow WAIT_PC and IDLE as normal; this power-on hold SHALL NOT increment rst_count.
REQ-024 Assertion of reset_n low mid-operation SHALL force the values of REQ-022 immediately, asynchronously.

Structure
REQ-025 A shared package SHALL hold the state enum and the cause-bit index constants (CAUSE_VRASED=0, CAUSE_CASU=1, CAUSE_GAROTA=2).
REQ-026 The down-counter with load and zero flag SHALL be a sub-module named hold_timer; all other logic SHALL be in viol_reset_ctrl.

Verification
REQ-027 The bench SHALL cover power-on: reset_n low 3 cycles then high, HOLD_CYCLES=8 -> cpu_rst high for 8 cycles after release; pc=0 -> IDLE; rst_count=0.
REQ-028 The bench SHALL cover a single violation: casu_viol one-cycle pulse in IDLE -> cpu_rst high for 8 cycles; rst_cause=3'b010; rst_count=1; busy until pc=16'h0000.
REQ-029 The bench SHALL cover extension: vrased_viol in IDLE, then garota_viol at hold cycle 5 -> hold lasts 13 cycles total; rst_cause=3'b101; rst_count=1.
REQ-030 The bench SHALL cover WAIT_PC re-entry: casu_viol and pc=16'h0000 on the same edge in WAIT_PC -> HOLD; rst_count increments by 1.
REQ-031 The bench SHALL cover saturation: 260 separate violations -> rst_count=8'hFF.
REQ-032 The bench SHALL cover clear: cause_clr in IDLE -> rst_cause=0; cause_clr together with vrased_viol -> rst_cause=3'b001; cause_clr during HOLD -> no change.

Source files
------------

// File: rtl/viol_reset_ctrl_pkg.sv
// Shared types and constants for the violation-driven CPU reset controller.
// Cause bits are ordered {garota, casu, vrased}.
package viol_reset_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_WAIT_PC = 2'd2
    } state_t;

    localparam int CAUSE_VRASED = 0;
    localparam int CAUSE_CASU   = 1;
    localparam int CAUSE_GAROTA = 2;

    localparam int CAUSE_W = 3;
    localparam int TIMER_W = 8;
    localparam int COUNT_W = 8;
    localparam int PC_W    = 16;

    // A hold length of zero is treated as one cycle, so the reload never underflows.
    function automatic logic [TIMER_W-1:0] hold_reload(input logic [7:0] hold_cycles);
        return (hold_cycles == 8'd0) ? '0 : (hold_cycles - 8'd1);
    endfunction

endpackage

// File: rtl/viol_reset_ctrl_hold_timer.sv
// Loadable down-counter that stops at zero and flags it.
// Comes out of reset pre-loaded so the power-on hold runs without a separate load.
module hold_timer #(
    parameter int           W         = 8,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= RESET_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/viol_reset_ctrl.sv
// Turns security-monitor violation requests into a timed CPU reset, then waits
// for the core to reach its reset handler before re-arming.
module viol_reset_ctrl
    import viol_reset_ctrl_pkg::*;
#(
    parameter logic [7:0]  HOLD_CYCLES   = 8'd8,
    parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [PC_W-1:0]    pc,
    input  logic               vrased_viol,
    input  logic               casu_viol,
    input  logic               garota_viol,
    input  logic               cause_clr,
    output logic               cpu_rst,
    output logic [CAUSE_W-1:0] rst_cause,
    output logic [COUNT_W-1:0] rst_count,
    output logic               busy
);

    localparam logic [TIMER_W-1:0] LP_RELOAD = hold_reload(HOLD_CYCLES);

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : (v + 1'b1);
    endfunction

    logic [CAUSE_W-1:0] w_viol;
    logic               w_any_viol;
    logic               w_pc_hit;
    logic               w_timer_load;
    logic               w_timer_dec;
    logic               w_timer_zero;

    state_t             r_state;
    logic               r_cpu_rst;
    logic               r_busy;
    logic [CAUSE_W-1:0] r_cause;
    logic [COUNT_W-1:0] r_count;

    assign w_viol[CAUSE_VRASED] = vrased_viol;
    assign w_viol[CAUSE_CASU]   = casu_viol;
    assign w_viol[CAUSE_GAROTA] = garota_viol;
    assign w_any_viol           = |w_viol;
    assign w_pc_hit             = (pc == RESET_HANDLER);

    // Every state that sees a violation ends up in (or stays in) HOLD with a fresh timer.
    assign w_timer_load = w_any_viol;
    assign w_timer_dec  = (r_state == ST_HOLD) && !w_any_viol && !w_timer_zero;

    hold_timer #(
        .W         (TIMER_W),
        .RESET_VAL (LP_RELOAD)
    ) u_hold_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_timer_load),
        .i_load_val (LP_RELOAD),
        .i_dec      (w_timer_dec),
        .o_zero     (w_timer_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_HOLD;
            r_cpu_rst <= 1'b1;
            r_busy    <= 1'b1;
            r_cause   <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_viol) begin
                        r_state   <= ST_HOLD;
                        r_cpu_rst <= 1'b1;
                        r_busy    <= 1'b1;
                        // A clear arriving with a violation keeps only the new cause.
                        r_cause   <= cause_clr ? w_viol : (r_cause | w_viol);
                        r_count   <= sat_inc(r_count);
                    end else if (cause_clr) begin
                        r_cause   <= '0;
                    end
                end
                ST_HOLD: begin
                    if (w_any_viol) begin
                        r_cause   <= r_cause | w_viol;
                    end else if (w_timer_zero) begin
                        r_state   <= ST_WAIT_PC;
                        r_cpu_rst <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_WAIT_PC: begin
                    if (w_any_viol) begin
                        r_state   <= ST_HOLD;
                        r_cpu_rst <= 1'b1;
                        r_busy    <= 1'b1;
                        r_cause   <= r_cause | w_viol;
                        r_count   <= sat_inc(r_count);
                    end else if (w_pc_hit) begin
                        r_state   <= ST_IDLE;
                        r_cpu_rst <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_HOLD;
                    r_cpu_rst <= 1'b1;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign cpu_rst   = r_cpu_rst;
    assign busy      = r_busy;
    assign rst_cause = r_cause;
    assign rst_count = r_count;

endmodule

// File: tb/tb_viol_reset_ctrl.sv
// Directed bench for viol_reset_ctrl with HOLD_CYCLES=8 and RESET_HANDLER=0.
module tb_viol_reset_ctrl;

    logic        clk         = 1'b0;
    logic        reset_n     = 1'b1;
    logic [15:0] pc          = 16'h1234;
    logic        vrased_viol = 1'b0;
    logic        casu_viol   = 1'b0;
    logic        garota_viol = 1'b0;
    logic        cause_clr   = 1'b0;
    logic        cpu_rst;
    logic [2:0]  rst_cause;
    logic [7:0]  rst_count;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    int n        = 0;

    viol_reset_ctrl #(
        .HOLD_CYCLES   (8'd8),
        .RESET_HANDLER (16'h0000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc          (pc),
        .vrased_viol (vrased_viol),
        .casu_viol   (casu_viol),
        .garota_viol (garota_viol),
        .cause_clr   (cause_clr),
        .cpu_rst     (cpu_rst),
        .rst_cause   (rst_cause),
        .rst_count   (rst_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts samples (current one included) for which cpu_rst stays high.
    task automatic count_high(output int len);
        len = 0;
        while (cpu_rst === 1'b1 && len < 100) begin
            len++;
            tick();
        end
    endtask

    task automatic go_idle();
        pc = 16'h0000;
        tick();
        pc = 16'h1234;
    endtask

    task automatic do_reset(input string tag);
        int len;
        reset_n = 1'b0;
        #1;
        check_val({tag, "_async_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
        check_val({tag, "_async_busy"},    {31'd0, busy},    32'd1);
        check_val({tag, "_async_cause"},   {29'd0, rst_cause}, 32'd0);
        check_val({tag, "_async_count"},   {24'd0, rst_count}, 32'd0);
        repeat (3) tick();
        check_val({tag, "_held_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
        reset_n = 1'b1;
        count_high(len);
        check_val({tag, "_hold_len"}, len, 32'd8);
        check_val({tag, "_waitpc_busy"}, {31'd0, busy}, 32'd1);
        tick();
        check_val({tag, "_waitpc_stays"}, {31'd0, busy}, 32'd1);
        go_idle();
        check_val({tag, "_idle_busy"},  {31'd0, busy}, 32'd0);
        check_val({tag, "_idle_count"}, {24'd0, rst_count}, 32'd0);
    endtask

    initial begin
        #2;
        do_reset("por");
        exp_cnt = 0;

        // single casu pulse from IDLE
        casu_viol = 1'b1;
        tick();
        casu_viol = 1'b0;
        check_val("single_rise", {31'd0, cpu_rst}, 32'd1);
        count_high(n);
        check_val("single_len", n, 32'd8);
        exp_cnt = 1;
        check_val("single_cause", {29'd0, rst_cause}, 32'h2);
        check_val("single_count", {24'd0, rst_count}, exp_cnt);
        tick();
        check_val("single_busy_waitpc", {31'd0, busy}, 32'd1);
        go_idle();
        check_val("single_idle", {31'd0, busy}, 32'd0);

        // start another reset, then pull reset_n mid-hold
        casu_viol = 1'b1;
        tick();
        casu_viol = 1'b0;
        check_val("midop_count_before", {24'd0, rst_count}, 32'd2);
        do_reset("midop");
        exp_cnt = 0;

        // extension: vrased, then garota during hold cycle 5
        vrased_viol = 1'b1;
        tick();
        vrased_viol = 1'b0;
        repeat (4) tick();
        check_val("ext_cycle5_high", {31'd0, cpu_rst}, 32'd1);
        garota_viol = 1'b1;
        tick();
        garota_viol = 1'b0;
        count_high(n);
        check_val("ext_total_len", 5 + n, 32'd13);
        exp_cnt = 1;
        check_val("ext_cause", {29'd0, rst_cause}, 32'h5);
        check_val("ext_count", {24'd0, rst_count}, exp_cnt);

        // violation beats pc match in WAIT_PC
        check_val("reentry_in_waitpc", {31'd0, busy & ~cpu_rst}, 32'd1);
        casu_viol = 1'b1;
        pc        = 16'h0000;
        tick();
        casu_viol = 1'b0;
        pc        = 16'h1234;
        exp_cnt   = 2;
        check_val("reentry_hold", {31'd0, cpu_rst}, 32'd1);
        check_val("reentry_count", {24'd0, rst_count}, exp_cnt);
        check_val("reentry_cause", {29'd0, rst_cause}, 32'h7);
        count_high(n);
        check_val("reentry_len", n, 32'd8);
        go_idle();
        check_val("reentry_idle", {31'd0, busy}, 32'd0);

        // cause_clr with a violation replaces the sticky bits
        cause_clr   = 1'b1;
        vrased_viol = 1'b1;
        tick();
        vrased_viol = 1'b0;
        exp_cnt     = 3;
        check_val("clr_viol_cause", {29'd0, rst_cause}, 32'h1);
        check_val("clr_viol_count", {24'd0, rst_count}, exp_cnt);
        tick();
        cause_clr = 1'b0;
        check_val("clr_in_hold_ignored", {29'd0, rst_cause}, 32'h1);
        count_high(n);
        check_val("clr_hold_len_rest", n, 32'd7);
        go_idle();
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        check_val("clr_idle_cause", {29'd0, rst_cause}, 32'h0);
        check_val("clr_idle_busy", {31'd0, busy}, 32'd0);

        // two monitors on the same edge count once
        vrased_viol = 1'b1;
        garota_viol = 1'b1;
        tick();
        vrased_viol = 1'b0;
        garota_viol = 1'b0;
        exp_cnt     = 4;
        check_val("multi_cause", {29'd0, rst_cause}, 32'h5);
        check_val("multi_count", {24'd0, rst_count}, exp_cnt);
        count_high(n);
        check_val("multi_len", n, 32'd8);

        // 260 separate resets re-entered from WAIT_PC
        for (int i = 0; i < 260; i++) begin
            casu_viol = 1'b1;
            tick();
            casu_viol = 1'b0;
            exp_cnt   = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            count_high(n);
            if (i == 9)   check_val("sat_mid",      {24'd0, rst_count}, exp_cnt);
            if (i == 250) check_val("sat_reach_ff", {24'd0, rst_count}, exp_cnt);
        end
        check_val("sat_final", {24'd0, rst_count}, 32'hFF);
        check_val("sat_cause", {29'd0, rst_cause}, 32'h7);
        go_idle();
        check_val("final_idle", {31'd0, busy}, 32'd0);
        check_val("final_count_kept", {24'd0, rst_count}, 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
